divider_control: RTL and testbench
==================================

Name: divider_control

Overview:
- Sequencing FSM for the 32-bit shift-subtract (restoring) divider.
- Sits directly upstream of the 64-bit remainder register and the 32-bit ALU, and drives their control strobes.
- Accepts a Start pulse and runs WIDTH subtract/shift iterations followed by a final upper-half correction shift.
- Flags completion with Ready and flags divide-by-zero with Div_err.

Parameters:
- WIDTH, 32, operand width; sets the iteration count.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  one-cycle request; sampled only in IDLE or DONE.
- Divisor_zero  input  1  divisor == 0; sampled together with Start.
- ALU_carry  input  1  1 = subtraction produced no borrow (upper half >= divisor).
- Load_ctrl  output  1  remainder register loads {0, dividend}.
- ALU_ctrl  output  1  ALU performs upper-half minus divisor.
- W_ctrl  output  1  remainder upper half takes ALU_result.
- SLL_ctrl  output  1  remainder shifts left 1, inserting Shift_in at bit 0.
- SRL_ctrl  output  1  remainder upper half shifts right 1 (final correction).
- Shift_in  output  1  quotient bit to insert on SLL.
- Busy  output  1  a division is in progress.
- Ready  output  1  result valid; held until the next accepted Start.
- Div_err  output  1  last request had a zero divisor.
- Iter  output  CNT_W  current iteration index, for debug and verification.

Behaviour:
- Reset (async): state=IDLE, Iter=0, Shift_in=0, Div_err=0. All control outputs are 0, including Ready and Busy.
- States: IDLE, INIT, SHIFT0, SUB, SHIFT, FINAL, DONE. Control outputs are Moore-decoded from the state register, except W_ctrl.
- IDLE: Start=1 and Divisor_zero=0 -> INIT, clear Div_err. Start=1 and Divisor_zero=1 -> DONE, set Div_err. Otherwise stay.
- INIT: Load_ctrl=1, Iter<=0 -> SHIFT0.
- SHIFT0: SLL_ctrl=1, Shift_in forced 0 -> SUB.
- SUB:
  - ALU_ctrl=1.
  - W_ctrl=ALU_carry (combinational). A borrow therefore leaves the upper half unwritten, which is the restore.
  - Shift_in<=ALU_carry (registered). -> SHIFT.
- SHIFT: SLL_ctrl=1, Iter<=Iter+1. If Iter==WIDTH-1 -> FINAL, else -> SUB.
- FINAL: SRL_ctrl=1 -> DONE.
- DONE: Ready=1, Busy=0. Start=1 restarts exactly as from IDLE (including the zero check); otherwise stay.
- Busy=1 in INIT, SHIFT0, SUB, SHIFT, FINAL. Start in these states is ignored and no pending request is latched.
- Mutual exclusion: at most one of Load_ctrl, SLL_ctrl, SRL_ctrl, W_ctrl is high in any cycle. ALU_ctrl is high only in SUB.
- Latency:
  - Start sampled at edge 0: INIT after edge 0, first SUB after edge 2, FINAL after edge 2*WIDTH+2, Ready high after edge 2*WIDTH+3 (67 for WIDTH=32).
  - Zero divisor: Ready high after edge 0 (1 cycle). No data strobes fire.
- Iter counts 0..WIDTH with no wrap; cleared in INIT. Holds WIDTH in DONE after a normal run.
- Reset asserted mid-run aborts immediately to IDLE with all strobes low; the datapath contents are don't-care.
- Start held high continuously from DONE: each DONE cycle accepts a new run. Ready is therefore high for exactly one cycle per run.

Decomposition:
- Shared package divider_pkg:
  - state enum div_state_t (7 states, 3-bit encoding).
  - constants DIV_WIDTH=32 and DIV_CNT_W=6.
  - ALU opcode constant ALU_SUB, shared with the ALU.
- One sub-module is natural: divider_iter_counter, with clear, increment, and terminal-count output (Iter==WIDTH-1).
- The FSM, output decode and Shift_in register stay in the top module.

Test Plan:
- Reset mid-run: Start, then Reset at SUB iteration 10 -> next sample shows IDLE, all strobes 0, Iter=0. Start after release gives a full 67-cycle run.
- Normal run, 100/7 with a remainder-register model attached:
  - Ready rises exactly 67 cycles after the Start edge.
  - Model shows quotient 14, remainder 2.
  - SUB count is 32, SHIFT count is 33, FINAL count is 1.
- All-borrow case, 3/0xFFFFFFFF: ALU_carry is 0 every SUB, so W_ctrl never asserts -> quotient 0, remainder 3. Shift_in=1 case, 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
- Divide-by-zero: Start with Divisor_zero=1 -> Ready and Div_err high one cycle later. Load_ctrl, SLL_ctrl, SRL_ctrl, W_ctrl, ALU_ctrl stay 0 throughout. A following valid Start clears Div_err.
- Busy and back-to-back:
  - Start pulses during Busy are ignored: run length is unchanged at 67 and there is no second run.
  - Start held high from DONE launches the next run on the cycle Ready is seen. Ready pulses once per run.
- Assertions run on every cycle:
  - strobe mutual exclusion;
  - ALU_ctrl implies state SUB;
  - Iter <= WIDTH.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and constants for the shift-subtract divider: FSM states,
// ALU opcodes and the per-state control-strobe decode.
package divider_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_CNT_W = 6;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_INIT   = 3'd1,
      S_SHIFT0 = 3'd2,
      S_SUB    = 3'd3,
      S_SHIFT  = 3'd4,
      S_FINAL  = 3'd5,
      S_DONE   = 3'd6
   } div_state_t;

   typedef enum logic {
      ALU_PASS = 1'b0,
      ALU_SUB  = 1'b1
   } alu_op_t;

   typedef struct packed {
      logic    load;
      alu_op_t alu_op;
      logic    sll;
      logic    srl;
      logic    busy;
      logic    ready;
   } ctrl_t;

   localparam ctrl_t CTRL_OFF = '{load: 1'b0, alu_op: ALU_PASS, sll: 1'b0,
                                  srl: 1'b0, busy: 1'b0, ready: 1'b0};

   // Moore strobes for a given state; W_ctrl is excluded because it also
   // depends on the live ALU carry.
   function automatic ctrl_t decode_ctrl(input div_state_t s);
      ctrl_t c;
      c = CTRL_OFF;
      case (s)
         S_INIT:   begin c.load = 1'b1;      c.busy = 1'b1; end
         S_SHIFT0: begin c.sll = 1'b1;       c.busy = 1'b1; end
         S_SUB:    begin c.alu_op = ALU_SUB; c.busy = 1'b1; end
         S_SHIFT:  begin c.sll = 1'b1;       c.busy = 1'b1; end
         S_FINAL:  begin c.srl = 1'b1;       c.busy = 1'b1; end
         S_DONE:   c.ready = 1'b1;
         default:  c = CTRL_OFF;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/divider_iter_counter.sv
// Iteration counter for the divider: synchronous clear, saturating increment
// and a terminal-count flag on the last iteration.
module divider_iter_counter
   import divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CNT_W = DIV_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             terminal
);

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count < CNT_MAX)) begin
         count <= count + 1'b1;
      end
   end

   assign terminal = (count == CNT_LAST);

endmodule

// File: rtl/divider_control.sv
// Sequencing FSM for the restoring shift-subtract divider; drives the
// remainder-register and ALU strobes and reports Ready / Div_err.
module divider_control
   import divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CNT_W = DIV_CNT_W
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Divisor_zero,
   input  logic             ALU_carry,
   output logic             Load_ctrl,
   output logic             ALU_ctrl,
   output logic             W_ctrl,
   output logic             SLL_ctrl,
   output logic             SRL_ctrl,
   output logic             Shift_in,
   output logic             Busy,
   output logic             Ready,
   output logic             Div_err,
   output logic [CNT_W-1:0] Iter
);

   div_state_t state, state_nxt;
   ctrl_t      ctrl_q;
   logic       iter_last;
   logic       accept;

   assign accept = Start && ((state == S_IDLE) || (state == S_DONE));

   // NOTE: always_comb assigns a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: if (Start) state_nxt = Divisor_zero ? S_DONE : S_INIT;
         S_INIT:         state_nxt = S_SHIFT0;
         S_SHIFT0:       state_nxt = S_SUB;
         S_SUB:          state_nxt = S_SHIFT;
         S_SHIFT:        state_nxt = iter_last ? S_FINAL : S_SUB;
         S_FINAL:        state_nxt = S_DONE;
         default:        state_nxt = S_IDLE;
      endcase
   end

   // Strobes are registered from the next state, so they match a Moore
   // decode of the state register without a combinational output path.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state    <= S_IDLE;
         ctrl_q   <= CTRL_OFF;
         Shift_in <= 1'b0;
         Div_err  <= 1'b0;
      end else begin
         state  <= state_nxt;
         ctrl_q <= decode_ctrl(state_nxt);
         if (accept)
            Div_err <= Divisor_zero;
         if (state == S_INIT)
            Shift_in <= 1'b0;
         else if (state == S_SUB)
            Shift_in <= ALU_carry;
      end
   end

   divider_iter_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_iter (
      .clk      (clk),
      .rst      (Reset),
      .clear    (state == S_INIT),
      .inc      (state == S_SHIFT),
      .count    (Iter),
      .terminal (iter_last)
   );

   assign Load_ctrl = ctrl_q.load;
   assign ALU_ctrl  = (ctrl_q.alu_op == ALU_SUB);
   assign SLL_ctrl  = ctrl_q.sll;
   assign SRL_ctrl  = ctrl_q.srl;
   assign Busy      = ctrl_q.busy;
   assign Ready     = ctrl_q.ready;

   // A borrow leaves the upper half unwritten, which is the restore step.
   assign W_ctrl    = (state == S_SUB) && ALU_carry;

endmodule

// File: tb/tb_divider_control.sv
// Self-checking bench for divider_control: a remainder-register datapath model
// closes the loop, and a phase-based protocol model is compared every cycle.
module tb_divider_control;

   localparam int WIDTH   = 32;
   localparam int CNT_W   = 6;
   localparam int RUN_LEN = 2 * WIDTH + 3;   // INIT..FINAL phases

   logic             clk = 1'b0;
   logic             Reset;
   logic             Start;
   logic             Divisor_zero;
   logic             ALU_carry;
   logic             Load_ctrl, ALU_ctrl, W_ctrl, SLL_ctrl, SRL_ctrl;
   logic             Shift_in, Busy, Ready, Div_err;
   logic [CNT_W-1:0] Iter;

   divider_control #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .Reset        (Reset),
      .Start        (Start),
      .Divisor_zero (Divisor_zero),
      .ALU_carry    (ALU_carry),
      .Load_ctrl    (Load_ctrl),
      .ALU_ctrl     (ALU_ctrl),
      .W_ctrl       (W_ctrl),
      .SLL_ctrl     (SLL_ctrl),
      .SRL_ctrl     (SRL_ctrl),
      .Shift_in     (Shift_in),
      .Busy         (Busy),
      .Ready        (Ready),
      .Div_err      (Div_err),
      .Iter         (Iter)
   );

   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Remainder register and ALU, driven by the DUT strobes.
   logic [31:0] dividend = '0;
   logic [31:0] divisor  = 32'd1;
   logic [63:0] rem      = '0;

   assign ALU_carry = (rem[63:32] >= divisor);

   always @(posedge clk) begin
      if (Load_ctrl)     rem <= {32'b0, dividend};
      else if (SLL_ctrl) rem <= {rem[62:0], Shift_in};
      else if (SRL_ctrl) rem[63:32] <= {1'b0, rem[63:33]};
      else if (W_ctrl)   rem[63:32] <= rem[63:32] - divisor;
   end

   // Protocol model: a run is a sequence of RUN_LEN phases after acceptance.
   typedef enum {M_IDLE, M_RUN, M_DONE} mode_t;
   mode_t       m_mode;
   int          m_c;
   logic        m_err;
   int          m_iter;
   logic [31:0] m_q;

   function automatic int iter_at(input int c);
      return (c < 2) ? 0 : (c - 2) / 2;
   endfunction

   always @(posedge clk or posedge Reset) begin
      if (Reset) begin
         m_mode <= M_IDLE;
         m_c    <= 0;
         m_err  <= 1'b0;
         m_iter <= 0;
         m_q    <= '0;
      end else begin
         case (m_mode)
            M_IDLE, M_DONE: if (Start) begin
               if (Divisor_zero) begin
                  m_mode <= M_DONE;
                  m_err  <= 1'b1;
               end else begin
                  m_mode <= M_RUN;
                  m_c    <= 0;
                  m_err  <= 1'b0;
                  m_q    <= dividend / divisor;
               end
            end
            M_RUN: begin
               m_c    <= m_c + 1;
               m_iter <= iter_at(m_c + 1);
               if (m_c == RUN_LEN - 1) m_mode <= M_DONE;
            end
            default: m_mode <= M_IDLE;
         endcase
      end
   end

   logic e_load, e_sll, e_alu, e_srl, e_w, e_si_valid, e_si, qb;
   int   k;

   always @(negedge clk) begin
      e_load = 1'b0; e_sll = 1'b0; e_alu = 1'b0; e_srl = 1'b0;
      e_w = 1'b0; e_si_valid = 1'b0; e_si = 1'b0; qb = 1'b0; k = 0;
      if (m_mode == M_RUN) begin
         if (m_c == 0) begin
            e_load = 1'b1;
         end else if (m_c == 1) begin
            e_sll = 1'b1; e_si_valid = 1'b1; e_si = 1'b0;
         end else if (m_c <= RUN_LEN - 2) begin
            k  = (m_c - 2) / 2;
            qb = m_q[31-k];
            if (m_c % 2 == 0) begin
               e_alu = 1'b1; e_w = qb;
            end else begin
               e_sll = 1'b1; e_si_valid = 1'b1; e_si = qb;
            end
         end else begin
            e_srl = 1'b1;
         end
      end
      check("cyc Load_ctrl", Load_ctrl, e_load);
      check("cyc SLL_ctrl",  SLL_ctrl,  e_sll);
      check("cyc ALU_ctrl",  ALU_ctrl,  e_alu);
      check("cyc SRL_ctrl",  SRL_ctrl,  e_srl);
      check("cyc W_ctrl",    W_ctrl,    e_w);
      check("cyc Busy",      Busy,      m_mode == M_RUN);
      check("cyc Ready",     Ready,     m_mode == M_DONE);
      check("cyc Div_err",   Div_err,   m_err);
      check("cyc Iter",      Iter,      m_iter);
      if (e_si_valid) check("cyc Shift_in", Shift_in, e_si);
      check("cyc mutex", $countones({Load_ctrl, SLL_ctrl, SRL_ctrl, W_ctrl}) <= 1, 1'b1);
      check("cyc iter_bound", Iter <= WIDTH, 1'b1);
   end

   task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_q, input logic [31:0] exp_r, input bit poke);
      int n, subs, shifts, finals;
      bit seen;
      dividend = a;
      divisor  = b;
      @(negedge clk);
      Start = 1'b1;
      Divisor_zero = (b == 0);
      @(posedge clk);
      #1;
      Start = 1'b0;
      Divisor_zero = 1'b0;
      n = 0; subs = 0; shifts = 0; finals = 0; seen = 0;
      while (n < 200 && !seen) begin
         @(posedge clk);
         n++;
         #1;
         subs   += int'(ALU_ctrl);
         shifts += int'(SLL_ctrl);
         finals += int'(SRL_ctrl);
         Start = poke && (n == 5 || n == 20 || n == 40);
         if (Ready) seen = 1;
      end
      Start = 1'b0;
      check({tag, " latency"}, n, (b == 0) ? 1 : RUN_LEN);
      check({tag, " Div_err"}, Div_err, b == 0);
      if (b != 0) begin
         check({tag, " sub_count"},   subs,   32);
         check({tag, " shift_count"}, shifts, 33);
         check({tag, " final_count"}, finals, 1);
         check({tag, " quotient"},    rem[31:0],  exp_q);
         check({tag, " remainder"},   rem[63:32], exp_r);
         check({tag, " iter_done"},   Iter, WIDTH);
      end
      if (poke) begin
         repeat (5) @(posedge clk);
         #1;
         check({tag, " no_second_run_ready"}, Ready, 1'b1);
         check({tag, " no_second_run_busy"},  Busy,  1'b0);
      end
   endtask

   initial begin
      int n, readies;
      bit found;
      Reset = 1'b1; Start = 1'b0; Divisor_zero = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset Ready",    Ready,    1'b0);
      check("reset Busy",     Busy,     1'b0);
      check("reset Iter",     Iter,     0);
      check("reset Shift_in", Shift_in, 1'b0);
      check("reset Div_err",  Div_err,  1'b0);
      check("reset strobes", {Load_ctrl, ALU_ctrl, W_ctrl, SLL_ctrl, SRL_ctrl}, 5'b0);
      @(negedge clk);
      Reset = 1'b0;

      run_div("100/7",      32'd100,        32'd7,          32'd14,         32'd2,    0);
      run_div("3/ffffffff", 32'd3,          32'hFFFF_FFFF,  32'd0,          32'd3,    0);
      run_div("ffffffff/1", 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,    0);
      run_div("123456789/12345", 32'd123456789, 32'd12345,  32'd10000,      32'd6789, 0);
      run_div("div0",       32'd5,          32'd0,          32'd0,          32'd0,    0);
      run_div("clear_err",  32'd1000000,    32'd3,          32'd333333,     32'd1,    1);

      // Abort at SUB iteration 10, then a clean run.
      dividend = 32'd100; divisor = 32'd7;
      @(negedge clk);
      Start = 1'b1;
      @(posedge clk);
      #1;
      Start = 1'b0;
      n = 0; found = 0;
      while (n < 100 && !found) begin
         if (ALU_ctrl && Iter == 10) found = 1;
         else begin
            @(posedge clk);
            n++;
            #1;
         end
      end
      check("midrun reached_sub10", found, 1'b1);
      Reset = 1'b1;
      #1;
      check("midrun strobes", {Load_ctrl, ALU_ctrl, W_ctrl, SLL_ctrl, SRL_ctrl}, 5'b0);
      check("midrun Iter",  Iter,  0);
      check("midrun Busy",  Busy,  1'b0);
      check("midrun Ready", Ready, 1'b0);
      @(negedge clk);
      Reset = 1'b0;
      run_div("after_reset", 32'd100, 32'd7, 32'd14, 32'd2, 0);

      // Start held high: a new run every RUN_LEN+1 cycles, one Ready cycle each.
      dividend = 32'd77; divisor = 32'd5;
      @(negedge clk);
      Start = 1'b1;
      @(posedge clk);
      readies = 0;
      for (int i = 1; i <= 3 * (RUN_LEN + 1) - 1; i++) begin
         @(posedge clk);
         #1;
         readies += int'(Ready);
      end
      Start = 1'b0;
      check("b2b ready_pulses", readies, 3);
      check("b2b ends_done", Ready, 1'b1);
      check("b2b quotient",  rem[31:0],  32'd15);
      check("b2b remainder", rem[63:32], 32'd2);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
